// File: rtl/s_p_ram_pkg.sv
// Shared definitions for the 8x16 single-port RAM initiator and its RAM model.
package s_p_ram_pkg;

    localparam int RAM_ADDR  = 3;
    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 1 << RAM_ADDR;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_ACC,
        R_TURN,
        CLR
    } state_t;

endpackage

// File: rtl/s_p_ram_master.sv
// Host-command initiator for an asynchronous single-port RAM on a shared tri-state bus.
// Strobes, address and bus enable are registered from the next state so they never glitch.
module s_p_ram_master
    import s_p_ram_pkg::*;
#(
    parameter int ADDR     = RAM_ADDR,
    parameter int WIDTH    = RAM_WIDTH,
    parameter int WAIT_CYC = 1,
    parameter int CLR_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic             cmd_clr,
    input  logic [ADDR-1:0]  cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_we,
    output logic             mem_re,
    output logic             mem_rst,
    output logic [ADDR-1:0]  mem_addr,
    inout  wire  [WIDTH-1:0] mem_data
);

    localparam int CNT_MAX = (WAIT_CYC + 1 > CLR_CYC) ? WAIT_CYC + 1 : CLR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] W_LEN = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] R_LEN = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] C_LEN = CNT_W'(CLR_CYC - 1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   wdata_q;
    logic               drv;
    logic               accept;
    logic               we_d, re_d, rst_d, drv_d, rsp_d;

    // Counter holds remaining cycles minus one for the state being entered.
    function automatic logic [CNT_W-1:0] reload(input state_t s);
        case (s)
            W_PULSE: reload = W_LEN;
            R_ACC:   reload = R_LEN;
            CLR:     reload = C_LEN;
            default: reload = '0;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign mem_data  = drv ? wdata_q : 'z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_rst   <= 1'b0;
            drv       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            mem_we    <= we_d;
            mem_re    <= re_d;
            mem_rst   <= rst_d;
            drv       <= drv_d;
            rsp_valid <= rsp_d;
            if (accept) begin
                mem_addr <= cmd_addr;
            end
            if (state == R_ACC && cnt == '0) begin
                rsp_rdata <= mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= cmd_wdata;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        if (state == IDLE) begin
            if (accept) begin
                if (cmd_clr)     next_state = CLR;
                else if (cmd_wr) next_state = W_SETUP;
                else             next_state = R_ACC;
            end
        end else if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end else begin
            case (state)
                W_SETUP: next_state = W_PULSE;
                W_PULSE: next_state = W_HOLD;
                R_ACC:   next_state = R_TURN;
                default: next_state = IDLE;
            endcase
        end
        if (next_state != state) begin
            cnt_next = reload(next_state);
        end
    end

    always_comb begin
        we_d  = (next_state == W_PULSE);
        re_d  = (next_state == R_ACC);
        rst_d = (next_state == CLR);
        drv_d = (next_state == W_SETUP) || (next_state == W_PULSE) || (next_state == W_HOLD);
        rsp_d = (next_state == W_HOLD) || (next_state == R_TURN) ||
                (next_state == CLR && cnt_next == '0);
    end

endmodule

// File: tb/tb_s_p_ram_master.sv
// Bench for s_p_ram_master with a behavioural 8x16 RAM on the shared bus.
module tb_s_p_ram_master;
    import s_p_ram_pkg::*;

    localparam int WAIT_CYC = 1;
    localparam int CLR_CYC  = 2;
    localparam int RW_LAT   = 2 + WAIT_CYC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_wr, cmd_clr;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        mem_we, mem_re, mem_rst;
    logic [2:0]  mem_addr;
    wire  [15:0] mem_data;

    always #5 clk = ~clk;

    s_p_ram_master #(.ADDR(3), .WIDTH(16), .WAIT_CYC(WAIT_CYC), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_clr(cmd_clr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rst(mem_rst),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // RAM model: drives the bus while read-enabled, captures writes and clears.
    logic [15:0] ram [RAM_DEPTH];
    assign mem_data = (mem_re && !mem_we) ? ram[mem_addr] : 'z;
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= '0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end
    end

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        logic        clr;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          busy;
        int          we_cyc;
        int          rst_cyc;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[$];
    logic [15:0] mdl [RAM_DEPTH];
    int n_chk = 0, n_fail = 0;
    int rsp_cnt = 0, we_cnt = 0, rst_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard pop and bus invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) we_cnt++;
            if (mem_rst) rst_cnt++;
            chk("we_re_excl", 32'(mem_we && mem_re), 32'd0);
            chk("rst_excl", 32'(mem_rst && (mem_we || mem_re)), 32'd0);
            chk("drv_excl", 32'(dut.drv && (mem_re || mem_rst)), 32'd0);
            if (rsp_valid) begin
                rsp_cnt++;
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, expected no pending command");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.is_read) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic run_cmd(input logic clr, input logic wr, input logic [2:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd,
                           output int lat, output int busy);
        int g;
        exp_t e;
        @(negedge clk);
        g = 0;
        while (!cmd_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        we_cnt = 0; rst_cnt = 0; rsp_cnt = 0;
        cmd_valid = 1'b1; cmd_clr = clr; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        e.is_read = !clr && !wr;
        e.rdata   = exp_rd;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wr    = $urandom_range(0, 1) != 0;
        cmd_clr   = $urandom_range(0, 1) != 0;
        cmd_addr  = 3'($urandom);
        cmd_wdata = 16'($urandom);
        lat = 0; busy = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!cmd_ready) busy++;
            if (rsp_valid && lat == 0) lat = n;
            if (cmd_ready) break;
        end
    endtask

    initial begin
        int lat, busy;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_clr = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_rst", 32'(mem_rst), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bus_drv", 32'(dut.drv), 32'd0);
        rst_n = 1'b1;

        tbl.push_back('{0, 1, 3'd3, 16'hA5C3, 16'h0000, RW_LAT, RW_LAT, WAIT_CYC, 0});
        tbl.push_back('{0, 0, 3'd3, 16'h0000, 16'hA5C3, RW_LAT, RW_LAT, 0, 0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 1, 3'(i), 16'(16'h1111 * i), 16'h0000, RW_LAT, RW_LAT, WAIT_CYC, 0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 0, 3'(i), 16'h0000, 16'(16'h1111 * i), RW_LAT, RW_LAT, 0, 0});
        tbl.push_back('{1, 0, 3'd0, 16'h0000, 16'h0000, CLR_CYC, CLR_CYC, 0, CLR_CYC});
        tbl.push_back('{0, 0, 3'd5, 16'h0000, 16'h0000, RW_LAT, RW_LAT, 0, 0});
        tbl.push_back('{0, 1, 3'd6, 16'hBEEF, 16'h0000, RW_LAT, RW_LAT, WAIT_CYC, 0});
        tbl.push_back('{1, 1, 3'd6, 16'hFFFF, 16'h0000, CLR_CYC, CLR_CYC, 0, CLR_CYC});
        tbl.push_back('{0, 0, 3'd6, 16'h0000, 16'h0000, RW_LAT, RW_LAT, 0, 0});

        foreach (tbl[k]) begin
            run_cmd(tbl[k].clr, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].rdata, lat, busy);
            chk("tbl_latency", 32'(lat), 32'(tbl[k].lat));
            chk("tbl_busy", 32'(busy), 32'(tbl[k].busy));
            chk("tbl_we_cycles", 32'(we_cnt), 32'(tbl[k].we_cyc));
            chk("tbl_rst_cycles", 32'(rst_cnt), 32'(tbl[k].rst_cyc));
            chk("tbl_rsp_count", 32'(rsp_cnt), 32'd1);
        end

        // Reset asserted while the write strobe is high.
        begin
            exp_t e;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_clr = 1'b0; cmd_wr = 1'b1; cmd_addr = 3'd2; cmd_wdata = 16'h1234;
            e.is_read = 1'b0; e.rdata = '0;
            sbq.push_back(e);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            chk("wsetup_drv", 32'(dut.drv), 32'd1);
            chk("wsetup_we", 32'(mem_we), 32'd0);
            @(negedge clk);
            chk("wpulse_we", 32'(mem_we), 32'd1);
            chk("wpulse_bus", 32'(mem_data), 32'h1234);
            rst_n = 1'b0;
            #1;
            chk("abort_we", 32'(mem_we), 32'd0);
            chk("abort_drv", 32'(dut.drv), 32'd0);
            chk("abort_rsp", 32'(rsp_valid), 32'd0);
            sbq.delete();
            rsp_cnt = 0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("abort_ready", 32'(cmd_ready), 32'd1);
            chk("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        end

        // Random traffic against a reference memory.
        run_cmd(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, lat, busy);
        for (int i = 0; i < RAM_DEPTH; i++) mdl[i] = '0;
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic c, w;
            logic [2:0] a;
            logic [15:0] d;
            r = int'($urandom_range(0, 9));
            c = (r == 0);
            w = (r < 5);
            a = 3'($urandom);
            d = 16'($urandom);
            if (c) begin
                for (int i = 0; i < RAM_DEPTH; i++) mdl[i] = '0;
            end else if (w) begin
                mdl[a] = d;
            end
            run_cmd(c, w, a, d, mdl[a], lat, busy);
            chk("rand_latency", 32'(lat), c ? 32'(CLR_CYC) : 32'(RW_LAT));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
